// File: rtl/fp_round_pkg.sv
// Shared types and default widths for the rounding pipeline.
package fp_round_pkg;
   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RUP = 3'd2,
      RM_RDN = 3'd3,
      RM_RMM = 3'd4
   } round_mode_e;
endpackage

// File: rtl/fp_round_pipe_round_incr.sv
// Round-increment decision from mode, sign, lsb, guard and sticky.
module round_incr
   import fp_round_pkg::*;
(
   input  logic [2:0] mode,
   input  logic       sign,
   input  logic       lsb,
   input  logic       g,
   input  logic       s,
   output logic       incr,
   output logic       inexact
);

   always_comb begin
      inexact = g | s;
      incr    = g & (s | lsb);
      // unused codes 5-7 fall into the default and round to nearest-even
      case (round_mode_e'(mode))
         RM_RTZ:  incr = 1'b0;
         RM_RUP:  incr = inexact & ~sign;
         RM_RDN:  incr = inexact & sign;
         RM_RMM:  incr = g;
         default: incr = g & (s | lsb);
      endcase
   end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage rounding pipeline: S1 decides and adds, S2 normalises and flags.
module fp_round_pipe
   import fp_round_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [MAN_W+2:0] in_mantis,
   input  logic             in_sticky,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_mantis,
   output logic             out_inexact,
   output logic             out_overflow,
   input  logic             flag_clr,
   output logic             sticky_inexact,
   output logic             sticky_overflow
);

   localparam int SUM_W = MAN_W + 2;

   logic             rnd_incr, rnd_inexact, in_special;
   logic [SUM_W-1:0] sum_d;

   logic             s1_valid, s1_sign, s1_inexact, s1_special;
   logic [EXP_W-1:0] s1_exp;
   logic [SUM_W-1:0] s1_sum;

   logic             s2_valid, s2_sign, s2_inexact, s2_overflow;
   logic [EXP_W-1:0] s2_exp;
   logic [MAN_W-1:0] s2_man;

   logic             n_ovf;
   logic [EXP_W-1:0] n_exp;
   logic [MAN_W-1:0] n_man;

   logic             s2_load, s1_advance;

   round_incr u_round_incr (
      .mode    (in_mode),
      .sign    (in_sign),
      .lsb     (in_mantis[2]),
      .g       (in_mantis[1]),
      .s       (in_mantis[0] | in_sticky),
      .incr    (rnd_incr),
      .inexact (rnd_inexact)
   );

   // inf/NaN inputs bypass rounding entirely
   assign in_special = &in_exp;
   assign sum_d      = {1'b0, in_mantis[MAN_W+2:2]}
                     + {{(SUM_W-1){1'b0}}, rnd_incr & ~in_special};

   assign s2_load    = ~s2_valid | out_ready;
   assign s1_advance = s1_valid & s2_load;
   assign in_ready   = ~s1_valid | s1_advance;

   always_comb begin
      n_exp = s1_exp;
      n_man = s1_sum[MAN_W-1:0];
      n_ovf = 1'b0;
      if (!s1_special) begin
         if (s1_sum[MAN_W+1]) begin
            n_exp = s1_exp + EXP_W'(1);
            n_man = '0;
         end else if (s1_exp == '0 && s1_sum[MAN_W]) begin
            n_exp = EXP_W'(1);
         end
         // rounding landed on the max exponent: saturate to infinity
         if (&n_exp) begin
            n_ovf = 1'b1;
            n_man = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid        <= 1'b0;
         s1_sign         <= 1'b0;
         s1_exp          <= '0;
         s1_sum          <= '0;
         s1_inexact      <= 1'b0;
         s1_special      <= 1'b0;
         s2_valid        <= 1'b0;
         s2_sign         <= 1'b0;
         s2_exp          <= '0;
         s2_man          <= '0;
         s2_inexact      <= 1'b0;
         s2_overflow     <= 1'b0;
         sticky_inexact  <= 1'b0;
         sticky_overflow <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sign    <= in_sign;
               s1_exp     <= in_exp;
               s1_sum     <= sum_d;
               s1_inexact <= rnd_inexact & ~in_special;
               s1_special <= in_special;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sign     <= s1_sign;
               s2_exp      <= n_exp;
               s2_man      <= n_man;
               s2_inexact  <= s1_inexact;
               s2_overflow <= n_ovf;
            end
         end
         if (flag_clr) begin
            sticky_inexact  <= 1'b0;
            sticky_overflow <= 1'b0;
         end else if (s2_valid && out_ready) begin
            sticky_inexact  <= sticky_inexact | s2_inexact;
            sticky_overflow <= sticky_overflow | s2_overflow;
         end
      end
   end

   assign out_valid    = s2_valid;
   assign out_sign     = s2_sign;
   assign out_exp      = s2_exp;
   assign out_mantis   = s2_man;
   assign out_inexact  = s2_inexact;
   assign out_overflow = s2_overflow;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe with directed rounding vectors.
module tb_fp_round_pipe;
   import fp_round_pkg::*;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic        inx;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_sign, in_sticky;
   logic [7:0]  in_exp;
   logic [25:0] in_mantis;
   logic [2:0]  in_mode;
   logic        out_valid, out_ready, out_sign, out_inexact, out_overflow;
   logic [7:0]  out_exp;
   logic [22:0] out_mantis;
   logic        flag_clr, sticky_inexact, sticky_overflow;

   res_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
      .in_sticky(in_sticky), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_mantis(out_mantis),
      .out_inexact(out_inexact), .out_overflow(out_overflow),
      .flag_clr(flag_clr),
      .sticky_inexact(sticky_inexact), .sticky_overflow(sticky_overflow)
   );

   function automatic logic [25:0] mk(logic h, logic [22:0] f, logic [1:0] r);
      mk = {h, f, r};
   endfunction

   function automatic res_t rs(logic s, logic [7:0] e, logic [22:0] m, logic i, logic o);
      rs = {s, e, m, i, o};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Caller is at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic s, input logic [7:0] e, input logic [25:0] m,
                       input logic st, input logic [2:0] md, input res_t r);
      int b;
      b = 0;
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mantis = m;
      in_sticky = st; in_mode = md;
      #1;
      while (!in_ready && b < 40) begin
         @(negedge clk); #1; b++;
      end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_ready stuck at %0b required 1", in_ready);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(r);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 40) begin
         @(negedge clk); b++;
      end
      repeat (2) @(negedge clk);
      chk("drain_left", exp_q.size(), 0);
   endtask

   // Monitor: pops one expectation for every completed output handshake.
   initial begin
      res_t r;
      forever begin
         @(negedge clk); #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_out: got %0h required none",
                        {out_sign, out_exp, out_mantis, out_inexact, out_overflow});
            end else begin
               r = exp_q.pop_front();
               chk("result", {out_sign, out_exp, out_mantis, out_inexact, out_overflow}, r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t required finish earlier", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, acc;
      logic [7:0] e;
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mantis = '0;
      in_sticky = 1'b0; in_mode = '0; out_ready = 1'b1; flag_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sticky", {sticky_inexact, sticky_overflow}, 0);
      chk("rst_data", {out_exp, out_mantis}, 0);
      @(negedge clk);

      // tie to even, with latency check
      send(0, 8'h7F, mk(1, 23'h000001, 2'b10), 0, RM_RNE, rs(0, 8'h7F, 23'h000002, 1, 0));
      in_valid = 1'b0;
      #1 chk("latency_early", out_valid, 0);
      @(negedge clk);
      #1 chk("latency_2cyc", out_valid, 1);
      @(negedge clk);

      // back-to-back stream
      send(0, 8'h80, mk(1, 23'h7FFFFF, 2'b11), 0, RM_RNE, rs(0, 8'h81, 23'h0, 1, 0));
      send(0, 8'hFE, mk(1, 23'h7FFFFF, 2'b11), 0, RM_RNE, rs(0, 8'hFF, 23'h0, 1, 1));
      send(1, 8'h40, mk(1, 23'h000000, 2'b01), 0, RM_RDN, rs(1, 8'h40, 23'h000001, 1, 0));
      send(1, 8'h40, mk(1, 23'h000000, 2'b01), 0, RM_RUP, rs(1, 8'h40, 23'h000000, 1, 0));
      send(1, 8'h40, mk(1, 23'h000000, 2'b01), 0, RM_RTZ, rs(1, 8'h40, 23'h000000, 1, 0));
      send(1, 8'h40, mk(1, 23'h000000, 2'b01), 0, RM_RNE, rs(1, 8'h40, 23'h000000, 1, 0));
      send(0, 8'h00, mk(0, 23'h7FFFFF, 2'b10), 0, RM_RNE, rs(0, 8'h01, 23'h0, 1, 0));
      send(0, 8'h20, mk(1, 23'h000002, 2'b10), 0, RM_RMM, rs(0, 8'h20, 23'h000003, 1, 0));
      send(0, 8'h20, mk(1, 23'h000002, 2'b10), 0, RM_RNE, rs(0, 8'h20, 23'h000002, 1, 0));
      send(0, 8'h20, mk(1, 23'h000002, 2'b10), 0, 3'd5,   rs(0, 8'h20, 23'h000002, 1, 0));
      send(1, 8'hFF, mk(1, 23'h123456, 2'b11), 1, RM_RUP, rs(1, 8'hFF, 23'h123456, 0, 0));
      send(0, 8'h55, mk(1, 23'h0ABCDE, 2'b00), 0, RM_RUP, rs(0, 8'h55, 23'h0ABCDE, 0, 0));
      send(0, 8'hFE, mk(1, 23'h7FFFFF, 2'b01), 0, RM_RUP, rs(0, 8'hFF, 23'h0, 1, 1));
      send(0, 8'hFE, mk(1, 23'h7FFFFF, 2'b11), 0, RM_RTZ, rs(0, 8'hFE, 23'h7FFFFF, 1, 0));
      send(0, 8'h33, mk(1, 23'h000000, 2'b00), 1, RM_RUP, rs(0, 8'h33, 23'h000001, 1, 0));
      in_valid = 1'b0;
      drain();
      #1 chk("sticky_after_stream", {sticky_inexact, sticky_overflow}, 2'b11);

      // reset while a result is held and sticky flags are set
      @(negedge clk);
      out_ready = 1'b0;
      send(0, 8'h10, mk(1, 23'h000005, 2'b00), 0, RM_RTZ, rs(0, 8'h10, 23'h000005, 0, 0));
      in_valid = 1'b0;
      @(negedge clk);
      #1 chk("pre_rst_valid", {out_valid, sticky_overflow}, 2'b11);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sticky", {sticky_inexact, sticky_overflow}, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);

      // flag_clr in the same cycle as an inexact handshake wins
      send(0, 8'h7F, mk(1, 23'h000001, 2'b10), 0, RM_RNE, rs(0, 8'h7F, 23'h000002, 1, 0));
      in_valid = 1'b0;
      @(negedge clk);
      #1 chk("clr_setup_valid", out_valid, 1);
      out_ready = 1'b1; flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      #1 chk("clr_wins", sticky_inexact, 0);
      @(negedge clk);
      send(0, 8'h7F, mk(1, 23'h000001, 2'b10), 0, RM_RNE, rs(0, 8'h7F, 23'h000002, 1, 0));
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("sticky_inexact_set", {sticky_inexact, sticky_overflow}, 2'b10);
      @(negedge clk);

      // back-pressure: 4 beats offered against a stalled sink
      out_ready = 1'b0;
      k = 0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         e = 8'(16 + k);
         if (k < 4) begin
            in_valid = 1'b1; in_sign = 1'b0; in_exp = e;
            in_mantis = mk(1, 23'(k + 1), 2'b00); in_sticky = 1'b0; in_mode = RM_RTZ;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(rs(0, e, 23'(k + 1), 0, 0));
            acc++; k++;
         end
         if (c >= 2) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {out_exp, out_mantis}, {8'h10, 23'h000001});
         end
         @(negedge clk);
      end
      #1;
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      while (k < 4) begin
         e = 8'(16 + k);
         send(0, e, mk(1, 23'(k + 1), 2'b00), 0, RM_RTZ, rs(0, e, 23'(k + 1), 0, 0));
         k++;
      end
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_round_pipe.md
FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width (hidden bit excluded).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_sign  input  1  sign, passed through unmodified.
REQ-008 in_exp  input  EXP_W  biased exponent; 0 = subnormal/zero.
REQ-009 in_mantis  input  MAN_W+3  {hidden, fraction[MAN_W-1:0], round bits R1 R0}.
REQ-010 in_sticky  input  1  OR of all bits discarded below R0.
REQ-011 in_mode  input  3  rounding mode, fp_round_pkg encoding.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_sign / out_exp / out_mantis  output  1 / EXP_W / MAN_W  rounded result.
REQ-015 out_inexact / out_overflow  output  1 / 1  per-result flags, valid with out_valid.
REQ-016 flag_clr  input  1  clears sticky flags.
REQ-017 sticky_inexact / sticky_overflow  output  1 / 1  accumulated flags.

Function
REQ-018 Modes SHALL be RNE=0, RTZ=1, RUP=2 (toward +inf), RDN=3 (toward -inf), RMM=4 (nearest, ties away); codes 5-7 SHALL behave as RNE.
REQ-019 Increment decision: lsb=fraction[0], G=R1, S=R0|in_sticky, inexact=G|S; RNE: G&(S|lsb); RMM: G; RTZ: 0; RUP: inexact&~sign; RDN: inexact&sign.
REQ-020 Sum = {hidden,fraction}+increment, MAN_W+2 bits wide.
REQ-021 Sum carry-out SHALL yield exp+1 and out_mantis=0 (exact, no bits lost).
REQ-022 in_exp=0 and sum hidden bit 1 (subnormal promotion) SHALL yield out_exp=1, out_mantis=sum[MAN_W-1:0].
REQ-023 out_exp all-ones after rounding SHALL set out_overflow and force out_mantis=0 (infinity) in every mode.
REQ-024 in_exp all-ones on input SHALL pass through unrounded, out_inexact=0, out_overflow=0.
REQ-025 Pipeline SHALL be two register stages: S1 registers increment decision and sum; S2 registers normalised result and flags; latency 2 cycles with no stall.
REQ-026 Each stage SHALL load when empty or when its successor accepts; in_ready = ~s1_valid | s1_advance; throughput one beat/cycle.
REQ-027 With out_ready=0, out_valid and all out_* SHALL hold stable; beats never dropped, duplicated or reordered.
REQ-028 sticky_* SHALL OR in out_* flags on each out_valid&out_ready handshake; flag_clr in the same cycle wins (result 0).

Reset
REQ-029 rst SHALL clear both stage valids, out_valid=0, sticky_inexact=0, sticky_overflow=0, and zero all data registers; in_ready=1 the cycle after.
REQ-030 rst mid-operation SHALL discard in-flight beats; no handshake completes in a reset cycle.

Structure
REQ-031 Package fp_round_pkg SHALL hold the round-mode enum and default EXP_W/MAN_W constants.
REQ-032 Increment decision SHALL be a combinational sub-module round_incr (mode, sign, lsb, G, S -> incr, inexact).

Verification (EXP_W=8, MAN_W=23)
REQ-033 RNE tie-to-even: exp=7F, mantis={1,000001,10}, sticky=0 -> exp 7F, mantis 000002, inexact=1, output 2 cycles later.
REQ-034 Carry/overflow: mantis={1,7FFFFF,11}, RNE, exp=80 -> exp 81, mantis 0; exp=FE -> exp FF, mantis 0, overflow=1, sticky_overflow=1.
REQ-035 Directed modes: sign=1, mantis={1,000000,01}: RDN -> 000001; RUP, RTZ, RNE -> 000000; all inexact=1.
REQ-036 Subnormal: exp=00, mantis={0,7FFFFF,10}, RNE -> exp 01, mantis 0.
REQ-037 Back-pressure: out_ready=0 for 6 cycles, 4 beats offered -> 2 accepted then in_ready=0; release -> 4 results in order, none lost.
REQ-038 Reset mid-stream: rst with out_valid=1 and sticky flags set -> next cycle out_valid=0, sticky flags 0, in_ready=1.
